// File: rtl/ntt_ctrl.sv
// Sequencing controller for the polynomial arithmetic unit: counter/mode for the address
// generator plus RAM read/write enables. Inter-stage drain gaps are built with NTT_STAGE_DRAIN_EN.
module ntt_ctrl #(
  parameter int LAT   = 7,
  parameter int DRAIN = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [1:0] mode_in,
  output logic [1:0] mode,
  output logic [7:0] clk_counter,
  output logic [2:0] stage,
  output logic       rd_en,
  output logic       wr_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FLUSH, S_DONE} state_e;
  typedef enum logic [1:0] {M_NTT, M_INVNTT, M_MULT, M_ADDSUB} mode_e;

  localparam int TMAX = (DRAIN > LAT) ? DRAIN : LAT;
  localparam int TW   = $clog2(TMAX + 1);

  state_e           state_q, state_d;
  mode_e            mode_q, mode_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [LAT-1:0]   pipe_q, pipe_d;
  logic             rd_en_q, rd_en_d;
  logic             wr_en_q, wr_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ntt_d;

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode_in);
          cnt_d   = 8'd0;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (!mode_q[1]) begin
          if (cnt_q == 8'd223) begin
            state_d = S_FLUSH;
            tmr_d   = TW'(LAT - 1);
          end
`ifdef NTT_STAGE_DRAIN_EN
          // Only stages 0..5 can end here: stage 6 ends at 223, caught above.
          else if (cnt_q[4:0] == 5'd31) begin
            state_d = S_DRAIN;
            tmr_d   = TW'(DRAIN - 1);
          end
`endif
          else begin
            cnt_d = cnt_q + 8'd1;
          end
        end else if (cnt_q == ((mode_q == M_MULT) ? 8'd140 : 8'd68)) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (tmr_q == '0) begin
          state_d = S_ISSUE;
          cnt_d   = cnt_q + 8'd1;
        end else begin
          tmr_d = tmr_q - TW'(1);
        end
      end
      S_FLUSH: begin
        if (tmr_q == '0) state_d = S_DONE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ntt_d = !mode_d[1];

    if (ntt_d)                 rd_en_d = (state_d == S_ISSUE);
    else if (mode_d == M_MULT) rd_en_d = (state_d == S_ISSUE) && (cnt_d < 8'd128);
    else                       rd_en_d = (state_d == S_ISSUE) && (cnt_d < 8'd64);

    // pipe_q[0] mirrors rd_en_q, so pipe_q[LAT-1] becomes the LAT-delayed read next cycle.
    pipe_d[0] = rd_en_d && ntt_d;
    for (int i = 1; i < LAT; i++) pipe_d[i] = pipe_q[i-1];

    // (c-13)[1:0]==3 reduces to c[1:0]==0; (c-5)[0]==1 reduces to c[0]==0.
    if (ntt_d)
      wr_en_d = pipe_q[LAT-1];
    else if (mode_d == M_MULT)
      wr_en_d = (state_d == S_ISSUE) && (cnt_d >= 8'd13) && (cnt_d <= 8'd140) && (cnt_d[1:0] == 2'b00);
    else
      wr_en_d = (state_d == S_ISSUE) && (cnt_d >= 8'd5) && (cnt_d <= 8'd68) && !cnt_d[0];

    busy_d = (state_d == S_ISSUE) || (state_d == S_DRAIN) || (state_d == S_FLUSH);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mode_q  <= M_NTT;
      cnt_q   <= 8'd0;
      tmr_q   <= '0;
      pipe_q  <= '0;
      rd_en_q <= 1'b0;
      wr_en_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples the pre-edge values computed above.
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      tmr_q   <= tmr_d;
      pipe_q  <= pipe_d;
      rd_en_q <= rd_en_d;
      wr_en_q <= wr_en_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mode        = mode_q;
  assign clk_counter = cnt_q;
  assign stage       = cnt_q[7:5];
  assign rd_en       = rd_en_q;
  assign wr_en       = wr_en_q;
  assign busy        = busy_q;
  assign done        = done_q;

endmodule

// File: tb/tb_ntt_ctrl.sv
// Directed bench for ntt_ctrl: a table of whole-operation vectors plus hand-written
// sequences for reset, start-while-busy, reset mid-NTT and start held high.
module tb_ntt_ctrl;

  localparam int LAT   = 7;
  localparam int DRAIN = 7;
`ifdef NTT_STAGE_DRAIN_EN
  localparam int NTT_BUSY   = 273;
  localparam int NTT_BURSTS = 7;
  localparam int NTT_HOLDS  = 6 * DRAIN + LAT;
`else
  localparam int NTT_BUSY   = 231;
  localparam int NTT_BURSTS = 1;
  localparam int NTT_HOLDS  = LAT;
`endif

  logic       clk = 1'b0;
  logic       rst, start;
  logic [1:0] mode_in;
  logic [1:0] mode;
  logic [7:0] clk_counter;
  logic [2:0] stage;
  logic       rd_en, wr_en, busy, done;

  ntt_ctrl #(.LAT(LAT), .DRAIN(DRAIN)) dut (
    .clk(clk), .rst(rst), .start(start), .mode_in(mode_in), .mode(mode),
    .clk_counter(clk_counter), .stage(stage), .rd_en(rd_en), .wr_en(wr_en),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] mode;
    int         inject_at;
    logic [1:0] inject_mode;
    int         busy;
    int         rd;
    int         wr;
    int         bursts;
    int         holds;
    int         first_wr;
    int         last_wr;
  } vec_t;

  vec_t vecs [4];
  int n_checks = 0;
  int n_fail   = 0;

  int   st_busy, st_rd, st_wr, st_bursts, st_holds, st_first_wr, st_last_wr;
  int   st_mode_errs, st_wr_errs, st_done_at, st_cnt0;
  logic st_busy1, st_rd1, st_done_after;
  logic rd_hist [0:2047];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [16:0] all_outs();
    return {mode, clk_counter, stage, rd_en, wr_en, busy, done};
  endfunction

  task automatic run_op(input logic [1:0] m, input int inject_at, input logic [1:0] inject_mode);
    logic [7:0] prev_cnt;
    logic       prev_rd, exp_wr;
    st_busy = 0; st_rd = 0; st_wr = 0; st_bursts = 0; st_holds = 0;
    st_first_wr = -1; st_last_wr = -1; st_mode_errs = 0; st_wr_errs = 0;
    st_done_at = 0; st_cnt0 = -1; st_busy1 = 1'b0; st_rd1 = 1'b0;
    prev_cnt = 8'd0; prev_rd = 1'b0;
    @(negedge clk);
    start = 1'b1; mode_in = m;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= 1000; c++) begin
      if (c == 1) begin
        st_cnt0 = int'(clk_counter); st_busy1 = busy; st_rd1 = rd_en;
      end
      if (done) begin
        st_done_at = c;
        break;
      end
      if (busy) begin
        st_busy++;
        if (c > 1 && clk_counter == prev_cnt) st_holds++;
      end
      if (rd_en) st_rd++;
      if (rd_en && !prev_rd) st_bursts++;
      if (wr_en) begin
        st_wr++;
        if (st_first_wr < 0) st_first_wr = int'(clk_counter);
        st_last_wr = int'(clk_counter);
      end
      if (mode != m) st_mode_errs++;
      if (!m[1])        exp_wr = (c > LAT) ? rd_hist[c-LAT] : 1'b0;
      else if (m == 2'd2) exp_wr = busy && clk_counter >= 13 && clk_counter <= 140 && ((clk_counter - 8'd13) % 4 == 3);
      else              exp_wr = busy && clk_counter >= 5 && clk_counter <= 68 && ((clk_counter - 8'd5) % 2 == 1);
      if (wr_en !== exp_wr) st_wr_errs++;
      rd_hist[c] = rd_en;
      prev_cnt = clk_counter;
      prev_rd  = rd_en;
      start = (c == inject_at);
      if (c == inject_at) mode_in = inject_mode;
      @(negedge clk);
    end
    start = 1'b0;
    @(negedge clk);
    st_done_after = done;
  endtask

  task automatic check_vec(input string tag, input vec_t v);
    check({tag, " cnt_at_start"}, st_cnt0, 0);
    check({tag, " busy_at_start"}, st_busy1, 1);
    check({tag, " rd_at_start"}, st_rd1, 1);
    check({tag, " busy_cycles"}, st_busy, v.busy);
    check({tag, " rd_cycles"}, st_rd, v.rd);
    check({tag, " wr_pulses"}, st_wr, v.wr);
    check({tag, " rd_bursts"}, st_bursts, v.bursts);
    check({tag, " counter_holds"}, st_holds, v.holds);
    check({tag, " first_wr_cnt"}, st_first_wr, v.first_wr);
    check({tag, " last_wr_cnt"}, st_last_wr, v.last_wr);
    check({tag, " mode_errors"}, st_mode_errs, 0);
    check({tag, " wr_timing_errors"}, st_wr_errs, 0);
    check({tag, " done_cycle"}, st_done_at, v.busy + 1);
    check({tag, " done_one_cycle"}, st_done_after, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr_seen;
    vecs[0] = '{2'd0, 0,  2'd0, NTT_BUSY, 224, 224, NTT_BURSTS, NTT_HOLDS, 7,  223};
    vecs[1] = '{2'd1, 50, 2'd3, NTT_BUSY, 224, 224, NTT_BURSTS, NTT_HOLDS, 7,  223};
    vecs[2] = '{2'd2, 0,  2'd0, 141,      128, 32,  1,          0,         16, 140};
    vecs[3] = '{2'd3, 0,  2'd0, 69,       64,  32,  1,          0,         6,  68};

    rst = 1'b0; start = 1'b0; mode_in = 2'd0;
    #2 rst = 1'b1;
    #1 check("reset_async_outputs", all_outs(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("reset_idle_outputs_%0d", i), all_outs(), 0);
    end

    for (int i = 0; i < 4; i++) begin
      run_op(vecs[i].mode, vecs[i].inject_at, vecs[i].inject_mode);
      check_vec($sformatf("vec%0d", i), vecs[i]);
    end

    // Asynchronous reset in the middle of a MULT run.
    @(negedge clk);
    start = 1'b1; mode_in = 2'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (20) @(negedge clk);
    check("mult_running_before_reset", busy, 1);
    #2 rst = 1'b1;
    #1 check("reset_mid_mult_outputs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("after_reset_idle_outputs", all_outs(), 0);

    // Reset mid-NTT at counter 100: pending writes must be discarded.
    start = 1'b1; mode_in = 2'd0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 400 && clk_counter != 8'd100; c++) @(negedge clk);
    check("mid_ntt_counter", clk_counter, 100);
    check("mid_ntt_rd_en", rd_en, 1);
    #2 rst = 1'b1;
    #1 check("reset_mid_ntt_outputs", all_outs(), 0);
    @(negedge clk);
    rst = 1'b0;
    wr_seen = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (wr_en) wr_seen++;
    end
    check("no_wr_after_reset", wr_seen, 0);
    check("idle_after_reset", busy, 0);
    run_op(2'd0, 0, 2'd0);
    check_vec("ntt_after_reset", vecs[0]);

    // start held high: exactly one IDLE cycle between back-to-back operations.
    @(negedge clk);
    start = 1'b1; mode_in = 2'd3;
    for (int c = 0; c < 200 && !done; c++) @(negedge clk);
    check("held_first_done", done, 1);
    @(negedge clk);
    check("held_gap_busy", busy, 0);
    check("held_gap_done", done, 0);
    @(negedge clk);
    check("held_restart_busy", busy, 1);
    check("held_restart_cnt", clk_counter, 0);
    check("held_restart_rd", rd_en, 1);
    start = 1'b0;
    for (int c = 0; c < 200 && !done; c++) @(negedge clk);
    check("held_second_done", done, 1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
